// File: rtl/ieee754_pkg.sv
// Shared IEEE754 single-precision definitions: field widths, FSM states and
// field-slice helpers used by the sequential subtractor and its aligner.
package ieee754_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   // Exponent register is two bits wider than the field so it can go negative or past 255
   localparam logic signed [EXP_W+1:0] EXP_MAX = 10'sd254;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic f_sign(input logic [EXP_W+MAN_W:0] x);
      return x[EXP_W+MAN_W];
   endfunction

   function automatic logic [EXP_W-1:0] f_exp(input logic [EXP_W+MAN_W:0] x);
      return x[EXP_W+MAN_W-1:MAN_W];
   endfunction

   function automatic logic [MAN_W:0] f_man_h(input logic [EXP_W+MAN_W:0] x);
      return {1'b1, x[MAN_W-1:0]};
   endfunction

endpackage

// File: rtl/ieee754_align.sv
// Combinational operand alignment: the larger exponent wins and the other
// mantissa (hidden bit included) is shifted right by the exponent difference.
module ieee754_align
   import ieee754_pkg::*;
(
   input  logic [EXP_W-1:0] i_exp_a,
   input  logic [EXP_W-1:0] i_exp_b,
   input  logic [MAN_W:0]   i_man_a,
   input  logic [MAN_W:0]   i_man_b,
   output logic [MAN_W:0]   o_man_a,
   output logic [MAN_W:0]   o_man_b,
   output logic [EXP_W-1:0] o_exp
);

   logic [EXP_W-1:0] w_diff;

   // Compare exponents and shift the smaller operand; gaps beyond the mantissa flush to zero
   always_comb begin
      w_diff  = '0;
      o_man_a = i_man_a;
      o_man_b = i_man_b;
      o_exp   = i_exp_a;
      if (i_exp_a >= i_exp_b) begin
         w_diff = i_exp_a - i_exp_b;
         o_exp  = i_exp_a;
         if (w_diff >= 8'(MAN_W + 1)) begin
            o_man_b = '0;
         end else begin
            o_man_b = i_man_b >> w_diff;
         end
      end else begin
         w_diff = i_exp_b - i_exp_a;
         o_exp  = i_exp_b;
         if (w_diff >= 8'(MAN_W + 1)) begin
            o_man_a = '0;
         end else begin
            o_man_a = i_man_a >> w_diff;
         end
      end
   end

endmodule

// File: rtl/ieee754_subtractor_seq.sv
// Multi-cycle IEEE754 single subtractor d = a - b: one cycle align/subtract,
// then one normalisation step per cycle, valid/ready on both sides.
module ieee754_subtractor_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [EXP_W+MAN_W:0]   i_a,
   input  logic [EXP_W+MAN_W:0]   i_b,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [EXP_W+MAN_W:0]   o_d,
   output logic                   o_overflow,
   output logic                   o_underflow
);
   import ieee754_pkg::state_t;
   import ieee754_pkg::IDLE;
   import ieee754_pkg::CALC;
   import ieee754_pkg::NORM;
   import ieee754_pkg::DONE;
   import ieee754_pkg::EXP_MAX;
   import ieee754_pkg::f_sign;
   import ieee754_pkg::f_exp;
   import ieee754_pkg::f_man_h;

   state_t                   r_state, w_state_nx;
   logic [EXP_W+MAN_W:0]     r_a, r_b, w_a_nx, w_b_nx;
   logic signed [EXP_W+1:0]  r_exp, w_exp_nx, w_exp_f;
   logic [MAN_W+1:0]         r_m, w_m_nx, w_m_f;
   logic                     r_sign, w_sign_nx, w_sign_f;
   logic [EXP_W+MAN_W:0]     r_d, w_d_nx;
   logic                     r_ovf, w_ovf_nx, r_unf, w_unf_nx;
   logic                     r_out_valid, w_out_valid_nx;
   logic                     w_fin, w_bn;
   logic [MAN_W:0]           w_man_a, w_man_b;
   logic [EXP_W-1:0]         w_exp_big;

   ieee754_align u_align (
      .i_exp_a (f_exp(r_a)),
      .i_exp_b (f_exp(r_b)),
      .i_man_a (f_man_h(r_a)),
      .i_man_b (f_man_h(r_b)),
      .o_man_a (w_man_a),
      .o_man_b (w_man_b),
      .o_exp   (w_exp_big)
   );

   assign w_bn        = ~f_sign(r_b);
   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = r_out_valid;
   assign o_d         = r_d;
   assign o_overflow  = r_ovf;
   assign o_underflow = r_unf;

   // Next-state and datapath decode for the accept / align / normalise / hold sequence
   always_comb begin
      w_state_nx     = r_state;
      w_a_nx         = r_a;
      w_b_nx         = r_b;
      w_exp_nx       = r_exp;
      w_m_nx         = r_m;
      w_sign_nx      = r_sign;
      w_d_nx         = r_d;
      w_ovf_nx       = r_ovf;
      w_unf_nx       = r_unf;
      w_out_valid_nx = r_out_valid;
      w_fin          = 1'b0;
      w_exp_f        = r_exp;
      w_m_f          = r_m;
      w_sign_f       = r_sign;
      case (r_state)
         IDLE: begin
            if (i_in_valid) begin
               w_a_nx     = i_a;
               w_b_nx     = i_b;
               w_state_nx = CALC;
            end else begin
               w_state_nx = IDLE;
            end
         end
         CALC: begin
            w_exp_nx   = $signed({2'b00, w_exp_big});
            w_state_nx = NORM;
            if (f_sign(r_a) == w_bn) begin
               w_m_nx    = {1'b0, w_man_a} + {1'b0, w_man_b};
               w_sign_nx = f_sign(r_a);
            end else if (w_man_a >= w_man_b) begin
               w_m_nx    = {1'b0, w_man_a - w_man_b};
               w_sign_nx = f_sign(r_a);
            end else begin
               w_m_nx    = {1'b0, w_man_b - w_man_a};
               w_sign_nx = w_bn;
            end
         end
         NORM: begin
            if (r_m[MAN_W+1]) begin
               w_fin   = 1'b1;
               w_exp_f = r_exp + 10'sd1;
               w_m_f   = r_m >> 1;
            end else if (r_m[MAN_W]) begin
               w_fin = 1'b1;
            end else if (r_m == '0) begin
               w_fin    = 1'b1;
               w_exp_f  = 10'sd0;
               w_sign_f = 1'b0;
            end else begin
               w_m_nx   = r_m << 1;
               w_exp_nx = r_exp - 10'sd1;
            end
            if (w_fin) begin
               w_exp_nx       = w_exp_f;
               w_m_nx         = w_m_f;
               w_sign_nx      = w_sign_f;
               w_out_valid_nx = 1'b1;
               w_state_nx     = DONE;
               // Out-of-range exponents saturate the field but keep the mantissa bits
               if (w_exp_f > EXP_MAX) begin
                  w_ovf_nx = 1'b1;
                  w_unf_nx = 1'b0;
                  w_d_nx   = {w_sign_f, 8'hFF, w_m_f[MAN_W-1:0]};
               end else if (w_exp_f < 10'sd0) begin
                  w_ovf_nx = 1'b0;
                  w_unf_nx = 1'b1;
                  w_d_nx   = {w_sign_f, 8'h00, w_m_f[MAN_W-1:0]};
               end else begin
                  w_ovf_nx = 1'b0;
                  w_unf_nx = 1'b0;
                  w_d_nx   = {w_sign_f, w_exp_f[EXP_W-1:0], w_m_f[MAN_W-1:0]};
               end
            end else begin
               w_state_nx = NORM;
            end
         end
         DONE: begin
            if (i_out_ready) begin
               w_out_valid_nx = 1'b0;
               w_state_nx     = IDLE;
            end else begin
               w_state_nx = DONE;
            end
         end
         default: begin
            w_state_nx     = IDLE;
            w_out_valid_nx = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_exp       <= '0;
         r_m         <= '0;
         r_sign      <= 1'b0;
         r_d         <= '0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_a         <= w_a_nx;
         r_b         <= w_b_nx;
         r_exp       <= w_exp_nx;
         r_m         <= w_m_nx;
         r_sign      <= w_sign_nx;
         r_d         <= w_d_nx;
         r_ovf       <= w_ovf_nx;
         r_unf       <= w_unf_nx;
         r_out_valid <= w_out_valid_nx;
      end
   end

endmodule

// File: tb/tb_ieee754_subtractor_seq.sv
// Directed self-checking bench for ieee754_subtractor_seq with hand-computed
// results, latency, stall and mid-operation reset checks.
module tb_ieee754_subtractor_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, d;
   logic        overflow, underflow;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   ieee754_subtractor_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_a         (a),
      .i_b         (b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_d         (d),
      .o_overflow  (overflow),
      .o_underflow (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Accept one operation and check latency, result and flags; optional consumer stall
   task automatic run_op(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] exp_d, input logic exp_ovf, input logic exp_unf,
                         input int lshift, input int stall);
      int   cyc;
      logic [31:0] d_hold;
      @(negedge clk);
      out_ready = (stall == 0);
      a         = ia;
      b         = ib;
      in_valid  = 1'b1;
      chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         #1 cyc++;
      end
      // out_valid first seen after edge T+2+L, so the consumer samples it at T+3+L
      chk({nm, ".latency"}, 32'(cyc + 1), 32'(3 + lshift));
      chk({nm, ".d"}, d, exp_d);
      chk({nm, ".ovf"}, 32'(overflow), 32'(exp_ovf));
      chk({nm, ".unf"}, 32'(underflow), 32'(exp_unf));
      d_hold = d;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk({nm, ".stall_valid"}, 32'(out_valid), 32'd1);
         chk({nm, ".stall_d"}, d, d_hold);
         chk({nm, ".stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      if (stall != 0) begin
         @(negedge clk);
         out_ready = 1'b1;
      end else begin
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({nm, ".post_valid"}, 32'(out_valid), 32'd0);
      chk({nm, ".post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'h0;
      b         = 32'h0;
      #12;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.d", d, 32'h0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      chk("rst.unf", 32'(underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("sub3m1",  32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 0, 5);
      run_op("zero",    32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 0, 0);
      run_op("carry",   32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 0, 0);
      run_op("long",    32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 1'b0, 1'b0, 23, 0);
      run_op("ovf",     32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 0, 0);
      run_op("unf",     32'h00C00000, 32'h00A00000, 32'h00000000, 1'b0, 1'b1, 2, 0);

      // Abort the long case while it is still normalising
      @(negedge clk);
      a        = 32'h3F800000;
      b        = 32'h3F7FFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      chk("abort.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("abort.rel_in_ready", 32'(in_ready), 32'd1);
      chk("abort.rel_out_valid", 32'(out_valid), 32'd0);
      run_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
